// File: rtl/mux_arbiter_2_pkg.sv
// mux_arbiter_2 shared types and defaults.
// No ports: arbiter state enum, default widths, counter width helper.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  localparam int ARB_DATA_W    = 4;
  localparam int ARB_MAX_BURST = 4;
  localparam int ARB_STAT_W    = 8;

  function automatic int arb_cnt_w(
    input int max_burst
  );
    return (max_burst > 1) ? $clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/mux_arbiter_2_if.sv
// mux_arbiter_2 bus: two requesters in, one registered beat out.
// master: req0/in0, req1/in1, out_ready out; slave drives acks, grants, sel, out_*.
interface mux_arbiter_2_if
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = ARB_DATA_W
);

  logic              req0;
  logic [DATA_W-1:0] in0;
  logic              req1;
  logic [DATA_W-1:0] in1;
  logic              ack0;
  logic              ack1;
  logic              grant0;
  logic              grant1;
  logic              sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_ready;

  modport master (
    output req0, in0,
    output req1, in1,
    output out_ready,
    input  ack0, ack1,
    input  grant0, grant1, sel,
    input  out_valid, out_data, out_src
  );

  modport slave (
    input  req0, in0,
    input  req1, in1,
    input  out_ready,
    output ack0, ack1,
    output grant0, grant1, sel,
    output out_valid, out_data, out_src
  );

endinterface

// File: rtl/mux_arbiter_2_mux2_w.sv
// mux2_w: combinational DATA_W-bit 2:1 select.
// Ports: sel (0 = in0, 1 = in1), in0, in1, y.
module mux2_w #(
  parameter int DATA_W = 4
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  output logic [DATA_W-1:0] y
);

  assign y = sel ? in1 : in0;

endmodule

// File: rtl/mux_arbiter_2.sv
// mux_arbiter_2: two-requester round-robin arbiter with burst limit
// and a single-entry registered output stage (valid/ready).
// Ports: clk, rst (async, active high), bus (mux_arbiter_2_if.slave);
// with ARB_STATS_EN defined also beats0/beats1 saturating ack counters.
module mux_arbiter_2
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = ARB_DATA_W,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input logic            clk,
  input logic            rst,
  mux_arbiter_2_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [ARB_STAT_W-1:0] beats0,
  output logic [ARB_STAT_W-1:0] beats1
`endif
);

  localparam int CNT_W = arb_cnt_w(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(MAX_BURST - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;

  logic              own1;
  logic              granted;
  logic              req_own;
  logic              req_oth;
  logic              load;
  logic              last_beat;
  arb_state_t        other_st;
  logic [DATA_W-1:0] mux_y;

  assign own1      = (state_q == GRANT1);
  assign granted   = (state_q != IDLE);
  assign req_own   = own1 ? bus.req1 : bus.req0;
  assign req_oth   = own1 ? bus.req0 : bus.req1;
  assign other_st  = own1 ? GRANT0 : GRANT1;
  assign last_beat = (cnt_q == CNT_LAST);
  assign load      = granted & req_own &
                     (~out_valid_q | bus.out_ready);

  mux2_w #(
    .DATA_W(DATA_W)
  ) u_mux (
    .sel(own1),
    .in0(bus.in0),
    .in1(bus.in1),
    .y  (mux_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        unique case (1'b1)
          bus.req0 & bus.req1: begin
            // tie goes to whoever did not own last
            state_d = last_q ? GRANT0 : GRANT1;
            last_d  = ~last_q;
          end
          bus.req0 & ~bus.req1: begin
            state_d = GRANT0;
            last_d  = 1'b0;
          end
          ~bus.req0 & bus.req1: begin
            state_d = GRANT1;
            last_d  = 1'b1;
          end
          default: ;
        endcase
      end
      GRANT0, GRANT1: begin
        if (!req_own) begin
          cnt_d = '0;
          if (req_oth) begin
            state_d = other_st;
            last_d  = ~own1;
          end else begin
            state_d = IDLE;
          end
        end else if (load) begin
          if (last_beat) begin
            // burst spent: hand over, or restart if alone
            cnt_d = '0;
            if (req_oth) begin
              state_d = other_st;
              last_d  = ~own1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_y;
      out_src_d   = own1;
    end else if (bus.out_ready & out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign bus.sel       = own1;
  assign bus.grant0    = (state_q == GRANT0);
  assign bus.grant1    = own1;
  assign bus.ack0      = load & ~own1;
  assign bus.ack1      = load & own1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

`ifdef ARB_STATS_EN
  logic [ARB_STAT_W-1:0] beats0_q, beats0_d;
  logic [ARB_STAT_W-1:0] beats1_q, beats1_d;

  always_comb begin
    beats0_d = beats0_q;
    beats1_d = beats1_q;
    if (load & ~own1 & (beats0_q != '1)) begin
      beats0_d = beats0_q + 1'b1;
    end
    if (load & own1 & (beats1_q != '1)) begin
      beats1_d = beats1_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats0_q <= '0;
      beats1_q <= '0;
    end else begin
      beats0_q <= beats0_d;
      beats1_q <= beats1_d;
    end
  end

  assign beats0 = beats0_q;
  assign beats1 = beats1_q;
`endif

endmodule

// File: tb/tb_mux_arbiter_2.sv
// Self-checking bench for mux_arbiter_2: directed scenarios
// plus a randomized run against a behavioural policy model.
module tb_mux_arbiter_2;

  localparam int DW = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mux_arbiter_2_if #(.DATA_W(DW)) bus ();

`ifdef ARB_STATS_EN
  logic [7:0] beats0;
  logic [7:0] beats1;
`endif

  mux_arbiter_2 #(
    .DATA_W   (DW),
    .MAX_BURST(MB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ARB_STATS_EN
    ,
    .beats0(beats0),
    .beats1(beats1)
`endif
  );

  function automatic logic [10:0] obs();
    return {bus.grant0, bus.grant1, bus.sel,
            bus.ack0, bus.ack1, bus.out_valid,
            bus.out_src, bus.out_data};
  endfunction

  task automatic clk_edge();
    logic a0, a1;
    a0 = bus.ack0;
    a1 = bus.ack1;
    @(posedge clk);
    #1;
    if (a0) bus.in0 = bus.in0 + 1'b1;
    if (a1) bus.in1 = bus.in1 + 1'b1;
  endtask

  task automatic do_reset();
    bus.req0 = 0; bus.req1 = 0;
    bus.in0 = '0; bus.in1 = '0;
    bus.out_ready = 0;
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h3; bus.in1 = 4'h7;
    bus.out_ready = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs() !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold got %b exp 0", obs());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b0 || bus.ack0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got g0=%b a0=%b exp 0 0",
               bus.grant0, bus.ack0);
    end
    clk_edge();
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1'b1 || bus.ack0 !== 1'b1 ||
        bus.grant1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_tie got g0=%b a0=%b g1=%b exp 1 1 0",
               bus.grant0, bus.ack0, bus.grant1);
    end
  endtask

  task automatic test_single();
    bit g1_seen;
    do_reset();
    bus.req0 = 1; bus.in0 = 4'hA;
    bus.out_ready = 1;
    g1_seen = 0;
    @(negedge clk);
    g1_seen |= bus.grant1;
    checks++;
    if (bus.grant0 !== 0 || bus.ack0 !== 0 ||
        bus.out_valid !== 0) begin
      errors++;
      $display("FAIL single_c0 got g0=%b a0=%b v=%b exp 0 0 0",
               bus.grant0, bus.ack0, bus.out_valid);
    end
    clk_edge();
    @(negedge clk);
    g1_seen |= bus.grant1;
    checks++;
    if (bus.grant0 !== 1 || bus.ack0 !== 1) begin
      errors++;
      $display("FAIL single_c1 got g0=%b a0=%b exp 1 1",
               bus.grant0, bus.ack0);
    end
    clk_edge();
    @(negedge clk);
    g1_seen |= bus.grant1;
    checks++;
    if (bus.out_valid !== 1 || bus.out_data !== 4'hA ||
        bus.out_src !== 0) begin
      errors++;
      $display("FAIL single_c2 got v=%b d=%h s=%b exp 1 a 0",
               bus.out_valid, bus.out_data, bus.out_src);
    end
    for (int i = 0; i < 4; i++) begin
      clk_edge();
      @(negedge clk);
      g1_seen |= bus.grant1;
    end
    checks++;
    if (g1_seen !== 1'b0) begin
      errors++;
      $display("FAIL single_no_grant1 got %b exp 0", g1_seen);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] dq[$];
    logic       sq[$];
    bit         gap;
    int         b;
    logic [3:0] ed;
    logic       es;
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h1; bus.in1 = 4'h9;
    bus.out_ready = 1;
    gap = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        dq.push_back(bus.out_data);
        sq.push_back(bus.out_src);
      end
      if (c >= 1 && !(bus.ack0 | bus.ack1)) gap = 1;
      clk_edge();
    end
    checks++;
    if (gap !== 1'b0 || dq.size() < 12) begin
      errors++;
      $display("FAIL rr_continuous got gap=%b n=%0d exp 0 >=12",
               gap, dq.size());
    end
    for (int k = 0; k < 12 && k < dq.size(); k++) begin
      b  = k / MB;
      es = logic'(b % 2);
      ed = 4'((es ? 9 : 1) + (b / 2) * MB + k % MB);
      checks++;
      if (dq[k] !== ed || sq[k] !== es) begin
        errors++;
        $display("FAIL rr_beat%0d got %h/%b exp %h/%b",
                 k, dq[k], sq[k], ed, es);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h5; bus.in1 = 4'h9;
    bus.out_ready = 0;
    @(negedge clk);
    clk_edge();
    @(negedge clk);
    checks++;
    if (bus.ack0 !== 1) begin
      errors++;
      $display("FAIL bp_first got a0=%b exp 1", bus.ack0);
    end
    clk_edge();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ack0 !== 0 || bus.ack1 !== 0 ||
          bus.out_valid !== 1 || bus.out_data !== 4'h5 ||
          bus.grant0 !== 1) begin
        errors++;
        $display("FAIL bp_stall%0d got a0=%b a1=%b v=%b d=%h g0=%b exp 0 0 1 5 1",
                 i, bus.ack0, bus.ack1, bus.out_valid,
                 bus.out_data, bus.grant0);
      end
      clk_edge();
    end
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.ack0 !== 1 || bus.grant0 !== 1) begin
        errors++;
        $display("FAIL bp_resume%0d got a0=%b g0=%b exp 1 1",
                 i, bus.ack0, bus.grant0);
      end
      if (i == 1) begin
        checks++;
        if (bus.out_data !== 4'h6) begin
          errors++;
          $display("FAIL bp_newbeat got %h exp 6", bus.out_data);
        end
      end
      clk_edge();
    end
    @(negedge clk);
    checks++;
    if (bus.grant1 !== 1 || bus.ack1 !== 1) begin
      errors++;
      $display("FAIL bp_handover got g1=%b a1=%b exp 1 1",
               bus.grant1, bus.ack1);
    end
  endtask

  task automatic test_drop();
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h1; bus.in1 = 4'h9;
    bus.out_ready = 1;
    @(negedge clk);
    clk_edge();
    @(negedge clk);
    clk_edge();
    @(negedge clk);
    clk_edge();
    bus.req0 = 0;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1 || bus.ack0 !== 0 || bus.ack1 !== 0) begin
      errors++;
      $display("FAIL drop_noack got g0=%b a0=%b a1=%b exp 1 0 0",
               bus.grant0, bus.ack0, bus.ack1);
    end
    clk_edge();
    for (int i = 0; i < MB; i++) begin
      @(negedge clk);
      checks++;
      if (bus.grant1 !== 1 || bus.ack1 !== 1) begin
        errors++;
        $display("FAIL drop_burst1_%0d got g1=%b a1=%b exp 1 1",
                 i, bus.grant1, bus.ack1);
      end
      clk_edge();
      bus.req0 = 1;
    end
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1 || bus.ack0 !== 1) begin
      errors++;
      $display("FAIL drop_back0 got g0=%b a0=%b exp 1 1",
               bus.grant0, bus.ack0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h1; bus.in1 = 4'h9;
    bus.out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      clk_edge();
    end
    @(negedge clk);
    checks++;
    if (bus.grant1 !== 1 || bus.out_valid !== 1) begin
      errors++;
      $display("FAIL areset_pre got g1=%b v=%b exp 1 1",
               bus.grant1, bus.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs() !== 11'd0) begin
      errors++;
      $display("FAIL areset_now got %b exp 0", obs());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 0 || bus.grant1 !== 0) begin
      errors++;
      $display("FAIL areset_idle got g0=%b g1=%b exp 0 0",
               bus.grant0, bus.grant1);
    end
    clk_edge();
    @(negedge clk);
    checks++;
    if (bus.grant0 !== 1 || bus.ack0 !== 1) begin
      errors++;
      $display("FAIL areset_first got g0=%b a0=%b exp 1 1",
               bus.grant0, bus.ack0);
    end
  endtask

  task automatic test_random();
    int          owner, last, taken, oth;
    bit          ov, os, rdy, can;
    logic [3:0]  od;
    bit          r[2];
    logic [3:0]  d[2];
    logic [10:0] exp_v;
    do_reset();
    owner = -1; last = 1; taken = 0;
    ov = 0; os = 0; od = '0;
    for (int c = 0; c < 600; c++) begin
      r[0] = ($urandom_range(0, 3) != 0);
      r[1] = ($urandom_range(0, 3) != 0);
      if (c >= 300) r[1] = ($urandom_range(0, 1) != 0);
      d[0] = 4'($urandom);
      d[1] = 4'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      bus.req0 = r[0]; bus.req1 = r[1];
      bus.in0 = d[0]; bus.in1 = d[1];
      bus.out_ready = rdy;
      @(negedge clk);
      can = (owner >= 0) && r[owner] && (!ov || rdy);
      exp_v = {owner == 0, owner == 1, owner == 1,
               can && owner == 0, can && owner == 1,
               ov, os, od};
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL random_c%0d got %b exp %b",
                 c, obs(), exp_v);
      end
      if (can) begin
        od = d[owner]; os = (owner == 1); ov = 1;
      end else if (rdy && ov) begin
        ov = 0;
      end
      if (owner < 0) begin
        if (r[0] && r[1]) owner = 1 - last;
        else if (r[0]) owner = 0;
        else if (r[1]) owner = 1;
        if (owner >= 0) last = owner;
        taken = 0;
      end else begin
        oth = 1 - owner;
        if (!r[owner]) begin
          taken = 0;
          if (r[oth]) begin
            owner = oth; last = oth;
          end else begin
            owner = -1;
          end
        end else if (can) begin
          taken++;
          if (taken == MB) begin
            taken = 0;
            if (r[oth]) begin
              owner = oth; last = oth;
            end
          end
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    bus.req0 = 1; bus.req1 = 1;
    bus.in0 = 4'h1; bus.in1 = 4'h9;
    bus.out_ready = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      clk_edge();
    end
    bus.req0 = 0; bus.req1 = 0;
    @(negedge clk);
    checks++;
    if (beats0 !== 8'd4 || beats1 !== 8'd4) begin
      errors++;
      $display("FAIL stats_rr got %0d/%0d exp 4/4",
               beats0, beats1);
    end
    bus.req0 = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      clk_edge();
    end
    @(negedge clk);
    checks++;
    if (beats0 !== 8'd255 || beats1 !== 8'd4) begin
      errors++;
      $display("FAIL stats_sat got %0d/%0d exp 255/4",
               beats0, beats1);
    end
  endtask
`endif

  initial begin
    bus.req0 = 0; bus.req1 = 0;
    bus.in0 = '0; bus.in1 = '0;
    bus.out_ready = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drop();
    test_async_reset();
    test_random();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
